// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
//   state_t   : controller states (IDLE, SEND, GAP)
//   PKT_CNT_W : width of the completed-packet counter
package axis_pkt_gen_pkg;

  localparam int unsigned PKT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits packets of incrementing data beats,
// with an optional idle gap after each packet and optional auto-restart.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, cont           : one-shot packet request / continuous restart
//   pkt_len, gap_cycles   : beats per packet / idle cycles after a packet
//   seed                  : first data value of a start-initiated packet
//   m_axis_valid/data/last: AXI-Stream master outputs (registered)
//   m_axis_ready          : downstream ready
//   busy, done, pkt_count : status (not idle / packet-complete pulse / count)
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  done,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [GAP_WIDTH-1:0]  gap_len_q, gap_len_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  valid_d, last_d, busy_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [PKT_CNT_W-1:0]  count_d;
  logic                  single_beat;

  assign single_beat = (len_q == LEN_WIDTH'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    valid_d   = m_axis_valid;
    data_d    = m_axis_data;
    last_d    = m_axis_last;
    busy_d    = busy;
    done_d    = 1'b0;
    count_d   = pkt_count;

    unique case (state_q)
      IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d   = SEND;
          len_d     = pkt_len;
          gap_len_d = gap_cycles;
          data_d    = seed;
          valid_d   = 1'b1;
          last_d    = (pkt_len == LEN_WIDTH'(1));
          beat_d    = '0;
          busy_d    = 1'b1;
        end
      end

      SEND: begin
        if (!m_axis_valid) begin
          // Zero-gap continuous restart: the cycle after the last beat is a
          // mandatory valid-low cycle, then the next packet begins here.
          valid_d = 1'b1;
          data_d  = m_axis_data + DATA_WIDTH'(1);
          last_d  = single_beat;
          beat_d  = '0;
        end else if (m_axis_ready) begin
          if (m_axis_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            count_d = pkt_count + PKT_CNT_W'(1);
            if (gap_len_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_len_q - GAP_WIDTH'(1);
            end else if (!cont) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            data_d = m_axis_data + DATA_WIDTH'(1);
            beat_d = beat_q + LEN_WIDTH'(1);
            last_d = ((beat_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          if (cont) begin
            state_d = SEND;
            valid_d = 1'b1;
            data_d  = m_axis_data + DATA_WIDTH'(1);
            last_d  = single_beat;
            beat_d  = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pkt_count    <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      gap_len_q    <= gap_len_d;
      gap_cnt_q    <= gap_cnt_d;
      m_axis_valid <= valid_d;
      m_axis_data  <= data_d;
      m_axis_last  <= last_d;
      busy         <= busy_d;
      done         <= done_d;
      pkt_count    <= count_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen. Inputs change on the
// falling edge; outputs are checked on the falling edge before new inputs.
module tb_axis_pkt_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        cont;
  logic [7:0]  pkt_len;
  logic [3:0]  gap_cycles;
  logic [7:0]  seed;
  logic        m_axis_valid;
  logic [7:0]  m_axis_data;
  logic        m_axis_last;
  logic        m_axis_ready;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  axis_pkt_gen #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (8),
    .GAP_WIDTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cont        (cont),
    .pkt_len     (pkt_len),
    .gap_cycles  (gap_cycles),
    .seed        (seed),
    .m_axis_valid(m_axis_valid),
    .m_axis_data (m_axis_data),
    .m_axis_last (m_axis_last),
    .m_axis_ready(m_axis_ready),
    .busy        (busy),
    .done        (done),
    .pkt_count   (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backpressure stability: a stalled beat must be unchanged one cycle later.
  logic       hold_chk = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  always @(posedge clk) begin
    hold_chk  <= reset_n && m_axis_valid && !m_axis_ready;
    hold_data <= m_axis_data;
    hold_last <= m_axis_last;
  end
  always @(negedge clk) begin
    if (hold_chk && reset_n) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== hold_data || m_axis_last !== hold_last) begin
        errors++;
        $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 m_axis_valid, m_axis_data, m_axis_last, hold_data, hold_last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (m_axis_valid !== 1'b0 || m_axis_data !== 8'h00 || m_axis_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h l=%b busy=%b done=%b cnt=%0d, required all 0",
               m_axis_valid, m_axis_data, m_axis_last, busy, done, pkt_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start = 1'b1; pkt_len = 8'd4; seed = 8'h10; gap_cycles = 4'd0; cont = 1'b0;
    m_axis_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'h10 + i) || m_axis_last !== (i == 3)) begin
        errors++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 i, m_axis_valid, m_axis_data, m_axis_last, 8'(8'h10 + i), (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (m_axis_valid !== 1'b0 || m_axis_last !== 1'b0 || done !== 1'b1 ||
        pkt_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got v=%b l=%b done=%b cnt=%0d busy=%b, required 0 0 1 1 0",
               m_axis_valid, m_axis_last, done, pkt_count, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_axis_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b v=%b, required 0 0", done, m_axis_valid);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic r = 1'b0;
    start = 1'b1; pkt_len = 8'd3; seed = 8'hFE; gap_cycles = 4'd0; cont = 1'b0;
    m_axis_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'hFE + idx) || m_axis_last !== (idx == 2)) begin
        errors++;
        $display("FAIL bp_beat%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 idx, m_axis_valid, m_axis_data, m_axis_last, 8'(8'hFE + idx), (idx == 2));
      end
      r = ~r;
      m_axis_ready = r;
      @(negedge clk);
      if (r) idx++;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL bp_timeout: got %0d beats, required 3", idx);
    end
    checks++;
    if (m_axis_valid !== 1'b0 || done !== 1'b1 || pkt_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_done: got v=%b done=%b cnt=%0d, required 0 1 2",
               m_axis_valid, done, pkt_count);
    end
    m_axis_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gap_cont();
    start = 1'b1; pkt_len = 8'd2; seed = 8'h40; gap_cycles = 4'd3; cont = 1'b1;
    m_axis_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'h40 + 2 * p + i) || m_axis_last !== (i == 1)) begin
          errors++;
          $display("FAIL gap_pkt%0d_beat%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   p, i, m_axis_valid, m_axis_data, m_axis_last, 8'(8'h40 + 2 * p + i), (i == 1));
        end
        if (p == 1) cont = 1'b0;
        @(negedge clk);
      end
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (busy !== 1'b1 || m_axis_valid !== 1'b0 || done !== (g == 0)) begin
          errors++;
          $display("FAIL gap_p%0d_cycle%0d: got busy=%b v=%b done=%b, required 1 0 %b",
                   p, g, busy, m_axis_valid, done, (g == 0));
        end
        @(negedge clk);
      end
    end
    checks++;
    if (busy !== 1'b0 || m_axis_valid !== 1'b0 || pkt_count !== 16'd4) begin
      errors++;
      $display("FAIL gap_end: got busy=%b v=%b cnt=%0d, required 0 0 4",
               busy, m_axis_valid, pkt_count);
    end
  endtask

  task automatic test_zero_len_and_ignore();
    start = 1'b1; pkt_len = 8'd0; seed = 8'h55; gap_cycles = 4'd0; cont = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_axis_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_len%0d: got busy=%b v=%b done=%b, required 0 0 0",
                 i, busy, m_axis_valid, done);
      end
    end
    pkt_len = 8'd3; seed = 8'h20;
    @(negedge clk);
    // Keep start high with different parameters while the packet is in flight.
    pkt_len = 8'd5; seed = 8'h99; gap_cycles = 4'd7;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'(8'h20 + i) || m_axis_last !== (i == 2)) begin
        errors++;
        $display("FAIL ignore_beat%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 i, m_axis_valid, m_axis_data, m_axis_last, 8'(8'h20 + i), (i == 2));
      end
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (m_axis_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || pkt_count !== 16'd5) begin
      errors++;
      $display("FAIL ignore_done: got v=%b done=%b busy=%b cnt=%0d, required 0 1 0 5",
               m_axis_valid, done, busy, pkt_count);
    end
    @(negedge clk);
  endtask

  task automatic test_cont_nogap();
    start = 1'b1; pkt_len = 8'd1; seed = 8'h7F; gap_cycles = 4'd0; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 8'h7F || m_axis_last !== 1'b1) begin
      errors++;
      $display("FAIL nogap_beat0: got v=%b d=%h l=%b, required 1 7f 1",
               m_axis_valid, m_axis_data, m_axis_last);
    end
    @(negedge clk);
    checks++;
    if (m_axis_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || pkt_count !== 16'd6) begin
      errors++;
      $display("FAIL nogap_done0: got v=%b done=%b busy=%b cnt=%0d, required 0 1 1 6",
               m_axis_valid, done, busy, pkt_count);
    end
    @(negedge clk);
    cont = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 8'h80 || m_axis_last !== 1'b1) begin
      errors++;
      $display("FAIL nogap_beat1: got v=%b d=%h l=%b, required 1 80 1",
               m_axis_valid, m_axis_data, m_axis_last);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_axis_valid !== 1'b0 || pkt_count !== 16'd7) begin
      errors++;
      $display("FAIL nogap_end: got busy=%b v=%b cnt=%0d, required 0 0 7",
               busy, m_axis_valid, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; pkt_len = 8'd5; seed = 8'h30; gap_cycles = 4'd0; cont = 1'b0;
    m_axis_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_axis_ready = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data !== 8'h31) begin
      errors++;
      $display("FAIL rst_pre: got v=%b d=%h, required 1 31", m_axis_valid, m_axis_data);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (m_axis_valid !== 1'b0 || m_axis_data !== 8'h00 || m_axis_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got v=%b d=%h l=%b busy=%b done=%b cnt=%0d, required all 0",
               m_axis_valid, m_axis_data, m_axis_last, busy, done, pkt_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_axis_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkt_count !== 16'd0) begin
        errors++;
        $display("FAIL rst_after%0d: got v=%b busy=%b done=%b cnt=%0d, required 0 0 0 0",
                 i, m_axis_valid, busy, done, pkt_count);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; cont = 1'b0; pkt_len = 8'd0; gap_cycles = 4'd0; seed = 8'h00;
    m_axis_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap_cont();
    test_zero_len_and_ignore();
    test_cont_nogap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of m_axis_data and seed.
REQ-002 Parameter LEN_WIDTH, default 8, width of pkt_len and the beat counter.
REQ-003 Parameter GAP_WIDTH, default 4, width of gap_cycles and the gap counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request one packet; sampled only in IDLE.
REQ-007 cont  input  1  auto-restart after gap while high.
REQ-008 pkt_len  input  LEN_WIDTH  beats per packet; 0 = no packet.
REQ-009 gap_cycles  input  GAP_WIDTH  idle cycles inserted after each packet.
REQ-010 seed  input  DATA_WIDTH  first data value of a start-initiated packet.
REQ-011 m_axis_valid  output  1  beat valid, registered.
REQ-012 m_axis_data  output  DATA_WIDTH  beat payload, registered.
REQ-013 m_axis_last  output  1  final beat of packet, registered.
REQ-014 m_axis_ready  input  1  downstream ready.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse, packet fully accepted.
REQ-017 pkt_count  output  16  packets completed, wraps at 2^16.

Function
REQ-018 States: IDLE, SEND, GAP; state register, outputs and counters all registered.
REQ-019 IDLE: start=1 with pkt_len!=0 latches pkt_len, gap_cycles and seed, moves to SEND; m_axis_valid=1 and m_axis_data=seed on the next cycle.
REQ-020 IDLE: start=1 with pkt_len=0 is ignored; no state change and no done.
REQ-021 start is ignored in SEND and GAP.
REQ-022 Handshake = m_axis_valid && m_axis_ready, at most one beat per cycle.
REQ-023 m_axis_valid, m_axis_data and m_axis_last hold stable while m_axis_valid=1 and m_axis_ready=0.
REQ-024 m_axis_valid does not depend combinationally on m_axis_ready; once asserted it stays high until the handshake.
REQ-025 After each handshake the next beat presents data+1, modulo 2^DATA_WIDTH (0xFF wraps to 0x00 at width 8).
REQ-026 m_axis_last=1 exactly on beat index latched_len-1; pkt_len=1 gives a single beat with last=1.
REQ-027 Back-to-back beats: with m_axis_ready held at 1, SEND emits one beat per cycle with no bubbles.
REQ-028 On the last-beat handshake: m_axis_valid=0, m_axis_last=0, done=1 and pkt_count increments, all on the next cycle.
REQ-029 After the last beat: latched gap=0 goes directly to IDLE; otherwise GAP for exactly latched gap cycles, then IDLE.
REQ-030 Restart with cont=1 at GAP exit (or at last handshake when gap=0): re-enter SEND with the latched length, data continues from last data+1, and the gap is not bypassed.
REQ-031 Inputs changed mid-packet have no effect until the next latch.

Reset
REQ-032 reset_n=0 asynchronously forces state=IDLE, m_axis_valid=0, m_axis_last=0, m_axis_data=0, busy=0, done=0, pkt_count=0 and all counters to 0.
REQ-033 Reset mid-packet abandons the packet (no done, no count); the first packet after release starts only on a new start.
REQ-034 Reset deassertion is synchronized by the integrating system; the block has no internal synchronizer.

Structure
REQ-035 The state enum typedef (IDLE/SEND/GAP) and the pkt_count width constant live in package axis_pkt_gen_pkg.
REQ-036 Implemented as a single module with no sub-module; it drives the slave port of the team's existing register-slice stage.

Verification
REQ-037 start, pkt_len=4, seed=0x10, gap=0, ready=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles; last on 0x13; done the next cycle; pkt_count=1.
REQ-038 pkt_len=3, seed=0xFE, ready toggling 1/0 each cycle -> data 0xFE,0xFF,0x00 with each beat held stable while ready=0; last only on 0x00.
REQ-039 pkt_len=2, gap=3, cont=1 -> 2 beats, busy high with valid low for 3 cycles, then next packet starts at data seed+2.
REQ-040 start with pkt_len=0 -> busy, valid and done all stay 0; start during SEND -> ignored, beat count unchanged.
REQ-041 reset_n low during beat 2 of 5 with ready=0 -> valid=0 and data=0 immediately without waiting for a clock; after release, no output until a new start.
REQ-042 Bench assertion throughout: valid high with ready low implies valid, data and last unchanged on the next cycle.
